// File: rtl/tcdm_stall_mem_pkg.sv
// Shared types and LFSR constants for the stall-injecting TCDM memory model.
package tcdm_mem_pkg;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  be_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One step of a right-shifting Galois LFSR.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/tcdm_stall_lfsr.sv
// Per-port 16-bit Galois LFSR driving pseudo-random grant stalls.
module tcdm_stall_lfsr
   import tcdm_mem_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [15:0] seed,
   output logic [15:0] state
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state <= seed;
      else if (en_i)
         state <= lfsr_next(state);
   end

endmodule

// File: rtl/tcdm_stall_mem.sv
// Multi-port word-addressed TCDM memory model with deterministic or LFSR-driven
// grant stalls; one-cycle response, highest port wins on same-cycle byte writes.
module tcdm_stall_mem
   import tcdm_mem_pkg::*;
#(
   parameter int          MP           = 2,
   parameter logic [31:0] BASE_ADDR    = 32'h1C000000,
   parameter int          MEM_WORDS    = 1024,
   parameter logic [7:0]  STALL_THRESH = 8'd128
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                randomize_i,
   input  logic                enable_i,
   input  logic                stallable_i,
   input  logic [MP-1:0]       tcdm_req_i,
   output logic [MP-1:0]       tcdm_gnt_o,
   input  word_t [MP-1:0]      tcdm_add_i,
   input  logic [MP-1:0]       tcdm_wen_i,
   input  be_t   [MP-1:0]      tcdm_be_i,
   input  word_t [MP-1:0]      tcdm_data_i,
   output logic [MP-1:0]       tcdm_r_valid_o,
   output word_t [MP-1:0]      tcdm_r_data_o
);

   localparam int          IW   = $clog2(MEM_WORDS);
   localparam logic [31:0] SPAN = 32'(MEM_WORDS) << 2;

   word_t memory [MEM_WORDS];

   // Only the LSB of the cycle counter selects the deterministic stall phase.
   logic                    cnt;
   logic [MP-1:0][15:0]     lfsr;
   logic [MP-1:0]           stall;
   logic [MP-1:0]           in_range;
   word_t [MP-1:0]          off;
   logic [MP-1:0][IW-1:0]   idx;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt <= 1'b0;
      else       cnt <= ~cnt;
   end

   for (genvar p = 0; p < MP; p++) begin : g_port
      tcdm_stall_lfsr u_lfsr (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .en_i  (randomize_i),
         .seed  (LFSR_SEED + 16'(p)),
         .state (lfsr[p])
      );

      assign stall[p] = stallable_i &
                        (randomize_i ? (lfsr[p][7:0] < STALL_THRESH) : (cnt == 1'(p)));
      assign tcdm_gnt_o[p] = tcdm_req_i[p] & enable_i & ~stall[p];

      // Comparing the full byte offset against the byte span keeps add[1:0] irrelevant.
      assign off[p]      = tcdm_add_i[p] - BASE_ADDR;
      assign in_range[p] = (tcdm_add_i[p] >= BASE_ADDR) && (off[p] < SPAN);
      assign idx[p]      = off[p][IW+1:2];
   end

   // Ascending port order lets the highest-index port win each byte.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < MP; p++)
         if (tcdm_gnt_o[p] && !tcdm_wen_i[p] && in_range[p])
            for (int b = 0; b < 4; b++)
               if (tcdm_be_i[p][b])
                  memory[idx[p]][8*b +: 8] <= tcdm_data_i[p][8*b +: 8];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tcdm_r_valid_o <= '0;
         tcdm_r_data_o  <= '0;
      end else begin
         tcdm_r_valid_o <= tcdm_gnt_o;
         for (int p = 0; p < MP; p++)
            if (tcdm_gnt_o[p])
               tcdm_r_data_o[p] <= in_range[p] ? memory[idx[p]] : '0;
      end
   end

endmodule

// File: tb/tb_tcdm_stall_mem.sv
// Scoreboard bench for tcdm_stall_mem: random traffic against a word-array model.
module tb_tcdm_stall_mem;

   localparam int          MP     = 2;
   localparam logic [31:0] BASE   = 32'h1C000000;
   localparam int          WORDS  = 1024;
   localparam int          THRESH = 128;

   logic clk = 1'b0, rst = 1'b1;
   logic randomize = 1'b0, enable = 1'b0, stallable = 1'b0;
   logic [MP-1:0]        req = '0, gnt, wen = '1, r_valid;
   logic [MP-1:0][31:0]  add = '0, wdata = '0, r_data;
   logic [MP-1:0][3:0]   be = '0;

   typedef struct { logic [31:0] add; logic wen; logic [3:0] be; logic [31:0] data; } tx_t;
   typedef struct { logic [31:0] d; bit care; } exp_t;

   tx_t         txq [MP][$];
   exp_t        expq [MP][$];
   tx_t         cur [MP];
   bit          cur_valid [MP];
   bit          granted_last [MP];
   logic [31:0] mem_m [WORDS];
   bit          known [WORDS];
   int          m_cnt;
   logic [15:0] m_lfsr [MP];
   logic [31:0] last_rdata [MP];
   int          gcount [MP], ccount [MP];
   bit          measure = 0, rnd_ctrl = 0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   tcdm_stall_mem #(.MP(MP), .BASE_ADDR(BASE), .MEM_WORDS(WORDS), .STALL_THRESH(8'(THRESH))) dut (
      .clk_i(clk), .rst_i(rst), .randomize_i(randomize), .enable_i(enable),
      .stallable_i(stallable), .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add),
      .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
      .tcdm_r_valid_o(r_valid), .tcdm_r_data_o(r_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_hit(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) / 4) < WORDS);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   // Model stall sources: cycle count since reset and a Galois LFSR per port.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt <= 0;
         for (int p = 0; p < MP; p++) begin
            m_lfsr[p] <= 16'hACE1 + 16'(p);
            expq[p].delete();
         end
      end else begin
         m_cnt <= m_cnt + 1;
         if (randomize)
            for (int p = 0; p < MP; p++)
               m_lfsr[p] <= m_lfsr[p][0] ? ((m_lfsr[p] >> 1) ^ 16'hB400) : (m_lfsr[p] >> 1);
      end
   end

   // Grant checker and expectation producer.
   always @(negedge clk) begin
      if (rst) begin
         for (int p = 0; p < MP; p++) begin
            chk("reset_r_valid", 32'(r_valid[p]), 32'h0);
            chk("reset_r_data", r_data[p], 32'h0);
            granted_last[p] = 0;
         end
      end else begin
         for (int p = 0; p < MP; p++) begin
            bit st, eg;
            st = stallable && (randomize ? (m_lfsr[p][7:0] < THRESH) : ((m_cnt % 2) == (p % 2)));
            eg = req[p] && enable && !st;
            chk("gnt", 32'(gnt[p]), 32'(eg));
            granted_last[p] = req[p] && gnt[p];
            if (measure && req[p]) ccount[p]++;
            if (measure && granted_last[p]) gcount[p]++;
         end
         for (int p = 0; p < MP; p++)
            if (granted_last[p]) begin
               exp_t e;
               if (m_hit(add[p])) begin
                  e.d = mem_m[m_idx(add[p])]; e.care = known[m_idx(add[p])];
               end else begin
                  e.d = 32'h0; e.care = 1;
               end
               expq[p].push_back(e);
            end
         for (int p = 0; p < MP; p++)
            if (granted_last[p] && !wen[p] && m_hit(add[p])) begin
               for (int b = 0; b < 4; b++)
                  if (be[p][b]) mem_m[m_idx(add[p])][8*b +: 8] = wdata[p][8*b +: 8];
               if (be[p] == 4'hF) known[m_idx(add[p])] = 1;
            end
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      if (rst) begin
         for (int p = 0; p < MP; p++) last_rdata[p] = 32'h0;
      end else begin
         for (int p = 0; p < MP; p++) begin
            if (r_valid[p]) begin
               if (expq[p].size() == 0) begin
                  checks++; errors++;
                  $display("FAIL spurious_r_valid port=%0d actual=1 required=0 t=%0t", p, $time);
               end else begin
                  exp_t e;
                  e = expq[p].pop_front();
                  if (e.care) begin
                     chk("r_data", r_data[p], e.d);
                     last_rdata[p] = e.d;
                  end else
                     last_rdata[p] = r_data[p];
               end
            end else
               chk("r_data_hold", r_data[p], last_rdata[p]);
         end
      end
   end

   // Driver: holds each request until granted.
   initial forever begin
      @(posedge clk); #1;
      for (int p = 0; p < MP; p++) begin
         if (cur_valid[p] && granted_last[p]) cur_valid[p] = 0;
         if (!cur_valid[p] && !rst && txq[p].size() > 0) begin
            cur[p] = txq[p].pop_front(); cur_valid[p] = 1;
         end
         req[p] = cur_valid[p]; add[p] = cur[p].add; wen[p] = cur[p].wen;
         be[p] = cur[p].be; wdata[p] = cur[p].data;
      end
      if (rnd_ctrl) begin
         enable    = ($urandom_range(0, 3) != 0);
         stallable = 1'($urandom_range(0, 1));
         randomize = 1'($urandom_range(0, 1));
      end
   end

   task automatic push(input int p, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d);
      tx_t t;
      t.add = a; t.wen = w; t.be = b; t.data = d;
      txq[p].push_back(t);
   endtask

   task automatic wait_idle(input int bound, input string name);
      bit idle = 0;
      for (int i = 0; i < bound && !idle; i++) begin
         @(negedge clk); #1;
         idle = 1;
         for (int p = 0; p < MP; p++)
            if (txq[p].size() != 0 || cur_valid[p] || expq[p].size() != 0) idle = 0;
      end
      if (!idle) begin
         checks++; errors++;
         $display("FAIL timeout_%s actual=busy required=idle t=%0t", name, $time);
      end
   endtask

   function automatic logic [31:0] rand_addr(input bit oor);
      int k;
      k = oor ? $urandom_range(0, 9) : 9;
      if (k == 0) return BASE + 32'h1000 + 4 * $urandom_range(0, 3);
      if (k == 1) return BASE - 4 * $urandom_range(1, 4);
      return BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
   endfunction

   task automatic rand_tx(input int p, input bit oor);
      push(p, rand_addr(oor), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
   endtask

   initial begin
      bit seen;
      repeat (3) @(posedge clk);
      #1 rst = 0; enable = 1;

      for (int i = 0; i < WORDS; i++) push(i % 2, BASE + 4 * i, 1'b0, 4'hF, 32'h0);
      wait_idle(2000, "clear");

      // Preload 0x11..0x88 and read back on port 0 with no stalls.
      for (int i = 0; i < 8; i++) push(0, BASE + 4 * i, 1'b0, 4'hF, 32'h11 * (i + 1));
      for (int i = 0; i < 8; i++) push(0, BASE + 4 * i, 1'b1, 4'h0, 32'h0);
      wait_idle(100, "preload");

      push(1, BASE + 32'h800, 1'b0, 4'b0101, 32'hAABBCCDD);
      push(1, BASE + 32'h800, 1'b1, 4'h0, 32'h0);
      wait_idle(50, "byte_enable");

      stallable = 1; randomize = 0;
      for (int i = 0; i < 40; i++) begin rand_tx(0, 0); rand_tx(1, 0); end
      wait_idle(400, "deterministic");

      randomize = 1;
      for (int i = 0; i < 1200; i++) begin
         push(0, rand_addr(0), 1'b0, 4'($urandom_range(0, 15)), $urandom);
         push(1, rand_addr(0), 1'b0, 4'($urandom_range(0, 15)), $urandom);
      end
      for (int p = 0; p < MP; p++) begin gcount[p] = 0; ccount[p] = 0; end
      @(negedge clk); measure = 1;
      repeat (1000) @(negedge clk);
      measure = 0;
      for (int p = 0; p < MP; p++) txq[p].delete();
      wait_idle(200, "random_drain");
      for (int p = 0; p < MP; p++) begin
         checks++;
         if (ccount[p] < 900 || gcount[p] * 100 < ccount[p] * 40 || gcount[p] * 100 > ccount[p] * 60) begin
            errors++;
            $display("FAIL grant_ratio port=%0d actual=%0d/%0d required=40-60pct", p, gcount[p], ccount[p]);
         end
      end
      stallable = 0;
      for (int i = 0; i < 32; i++) push(i % 2, BASE + 4 * i, 1'b1, 4'h0, 32'h0);
      wait_idle(100, "random_readback");

      // Same-cycle collisions: write/write on word 40, read/write on word 41.
      push(0, BASE + 4 * 40, 1'b0, 4'hF, 32'h1);
      push(1, BASE + 4 * 40, 1'b0, 4'hF, 32'h2);
      push(0, BASE + 4 * 41, 1'b1, 4'h0, 32'h0);
      push(1, BASE + 4 * 41, 1'b0, 4'hF, 32'h12345678);
      push(0, BASE + 4 * 40, 1'b1, 4'h0, 32'h0);
      push(1, BASE + 4 * 41, 1'b1, 4'h0, 32'h0);
      wait_idle(50, "collision");

      rnd_ctrl = 1;
      for (int i = 0; i < 300; i++) begin rand_tx(0, 1); rand_tx(1, 1); end
      wait_idle(5000, "mixed");
      rnd_ctrl = 0; enable = 1; stallable = 0; randomize = 0;

      push(0, BASE + 32'h1000, 1'b1, 4'h0, 32'h0);
      push(1, BASE + 32'h1000, 1'b0, 4'hF, 32'hDEADBEEF);
      push(0, BASE - 4, 1'b1, 4'h0, 32'h0);
      push(1, BASE, 1'b1, 4'h0, 32'h0);
      wait_idle(50, "out_of_range");

      // Reset while a read response is pending.
      push(0, BASE + 4 * 3, 1'b1, 4'h0, 32'h0);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #1;
         seen = granted_last[0];
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL timeout_reset_grant actual=no_grant required=grant t=%0t", $time);
      end
      #1 rst = 1;
      @(negedge clk); #1;
      chk("reset_drops_r_valid", 32'(r_valid[0]), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      stallable = 1;
      for (int i = 0; i < 8; i++) push(i % 2, BASE + 4 * i, 1'b1, 4'h0, 32'h0);
      push(0, BASE + 32'h800, 1'b1, 4'h0, 32'h0);
      wait_idle(100, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
